// File: rtl/pc_gen_pkg.sv
// Shared defaults, next-PC select encoding and target alignment helper for pc_gen.
package pc_gen_pkg;

  localparam int unsigned PCLEN_DEF     = 10;
  localparam int unsigned INC_DEF       = 4;
  localparam int unsigned RAS_DEPTH_DEF = 4;

  typedef enum logic [2:0] {
    SEL_BRANCH,
    SEL_JUMP,
    SEL_RET,
    SEL_SEQ,
    SEL_HOLD
  } pc_sel_e;

  // Bits below the fetch granule; these are cleared in every redirect target.
  function automatic logic [31:0] align_mask(input int unsigned inc);
    return inc - 32'd1;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: push overwrites the oldest entry when full,
// pop on empty leaves the stack untouched and sets a sticky error.
module pc_ras #(
  parameter int unsigned PCLEN = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [PCLEN-1:0] push_data,
  input  logic             pop,
  output logic [PCLEN-1:0] top,
  output logic             empty,
  output logic             full,
  output logic             err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [PCLEN-1:0] mem [DEPTH];
  logic [AW-1:0]    ptr;
  logic [CW-1:0]    count;

  // ptr addresses the next free slot; the top of stack sits just below it.
  assign top   = mem[ptr - AW'(1)];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  always_ff @(posedge clk) begin
    if (push) mem[ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr   <= '0;
      count <= '0;
      err   <= 1'b0;
    end else if (push) begin
      ptr <= ptr + AW'(1);
      if (!full) count <= count + CW'(1);
    end else if (pop) begin
      if (empty) begin
        err <= 1'b1;
      end else begin
        ptr   <= ptr - AW'(1);
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program counter with branch/jump/return redirect and stall.
// Define PCGEN_RAS_EN to build the return-address stack for call/return prediction.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned      PCLEN     = PCLEN_DEF,
  parameter int unsigned      INC       = INC_DEF,
  parameter logic [PCLEN-1:0] RESET_PC  = '0,
  parameter int unsigned      RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [PCLEN-1:0] br_target,
  input  logic             jump,
  input  logic [PCLEN-1:0] jump_target,
  input  logic             call,
  input  logic             ret,
  output logic [PCLEN-1:0] pc,
  output logic [PCLEN-1:0] pc_last,
  output logic [PCLEN-1:0] pc_next,
  output logic             misalign,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_err
);

  localparam logic [PCLEN-1:0] LOW_MASK = PCLEN'(align_mask(INC));
  localparam logic [PCLEN-1:0] STEP     = PCLEN'(INC);

  pc_sel_e          sel;
  logic [PCLEN-1:0] raw_target;
  logic [PCLEN-1:0] ret_target;
  logic             redirect;

`ifdef PCGEN_RAS_EN
  logic [PCLEN-1:0] ras_top;

  // sel already resolves priority, so losing call/ret requests never touch the stack.
  pc_ras #(
    .PCLEN (PCLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      ((sel == SEL_JUMP) && call),
    .push_data (pc + STEP),
    .pop       (sel == SEL_RET),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full),
    .err       (ras_err)
  );

  assign ret_target = ras_empty ? jump_target : ras_top;
`else
  logic unused_call;

  assign unused_call = call;
  assign ret_target  = jump_target;
  assign ras_empty   = 1'b1;
  assign ras_full    = 1'b0;
  assign ras_err     = 1'b0;
`endif

  always_comb begin
    sel = SEL_HOLD;
    if (br_taken)    sel = SEL_BRANCH;
    else if (jump)   sel = SEL_JUMP;
    else if (ret)    sel = SEL_RET;
    else if (!stall) sel = SEL_SEQ;
  end

  always_comb begin
    raw_target = br_target;
    redirect   = 1'b1;
    pc_next    = pc;
    case (sel)
      SEL_BRANCH: raw_target = br_target;
      SEL_JUMP:   raw_target = jump_target;
      SEL_RET:    raw_target = ret_target;
      default:    redirect   = 1'b0;
    endcase
    if (redirect)            pc_next = raw_target & ~LOW_MASK;
    else if (sel == SEL_SEQ) pc_next = pc + STEP;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      pc_last  <= RESET_PC;
      misalign <= 1'b0;
    end else begin
      if (sel != SEL_HOLD) pc_last <= pc;
      pc       <= pc_next;
      misalign <= redirect && |(raw_target & LOW_MASK);
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed plus randomized bench for pc_gen against a queue-based reference model.
module tb_pc_gen;

  localparam int unsigned PCLEN = 10;
  localparam int unsigned INC   = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned MOD   = 1 << PCLEN;
`ifdef PCGEN_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             stall = 1'b1;
  logic             br_taken = 1'b0;
  logic [PCLEN-1:0] br_target = '0;
  logic             jump = 1'b0;
  logic [PCLEN-1:0] jump_target = '0;
  logic             call = 1'b0;
  logic             ret = 1'b0;
  logic [PCLEN-1:0] pc, pc_last, pc_next;
  logic             misalign, ras_empty, ras_full, ras_err;

  pc_gen #(
    .PCLEN     (PCLEN),
    .INC       (INC),
    .RESET_PC  (10'h000),
    .RAS_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .jump        (jump),
    .jump_target (jump_target),
    .call        (call),
    .ret         (ret),
    .pc          (pc),
    .pc_last     (pc_last),
    .pc_next     (pc_next),
    .misalign    (misalign),
    .ras_empty   (ras_empty),
    .ras_full    (ras_full),
    .ras_err     (ras_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  int unsigned m_pc = 0;
  int unsigned m_last = 0;
  bit          m_mis = 1'b0;
  bit          m_err = 1'b0;
  int unsigned ras_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_state();
    chk("pc", pc, m_pc);
    chk("pc_last", pc_last, m_last);
    chk("misalign", misalign, m_mis);
    chk("ras_empty", ras_empty, RAS_ON ? (ras_q.size() == 0) : 1);
    chk("ras_full", ras_full, RAS_ON ? (ras_q.size() == DEPTH) : 0);
    chk("ras_err", ras_err, m_err);
  endtask

  // Assert reset between clock edges; the PC must clear without waiting for a clock.
  task automatic mid_reset();
    #2 rst = 1'b1;
    #1;
    m_pc = 0; m_last = 0; m_mis = 1'b0; m_err = 1'b0;
    ras_q.delete();
    chk("rst_pc", pc, 0);
    chk("rst_pc_last", pc_last, 0);
    chk("rst_misalign", misalign, 0);
    chk("rst_ras_err", ras_err, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step(input bit s, input bit b, input int unsigned bt,
                      input bit j, input int unsigned jt, input bit c, input bit r);
    int unsigned t  = 0;
    int unsigned np = 0;
    bit          redir = 1'b0;
    bit          mis   = 1'b0;
    stall = s; br_taken = b; br_target = bt[PCLEN-1:0];
    jump = j; jump_target = jt[PCLEN-1:0]; call = c; ret = r;
    if (b) begin
      t = bt; redir = 1'b1;
    end else if (j) begin
      t = jt; redir = 1'b1;
      if (RAS_ON && c) begin
        ras_q.push_back((m_pc + INC) % MOD);
        if (ras_q.size() > DEPTH) void'(ras_q.pop_front());
      end
    end else if (r) begin
      redir = 1'b1;
      if (RAS_ON && ras_q.size() > 0) t = ras_q.pop_back();
      else begin
        t = jt;
        if (RAS_ON) m_err = 1'b1;
      end
    end
    if (redir) begin
      np  = t - (t % INC);
      mis = (t % INC) != 0;
    end else if (!s) np = (m_pc + INC) % MOD;
    else             np = m_pc;
    #1 chk("pc_next", pc_next, np);
    @(posedge clk);
    #1;
    if (redir || !s) m_last = m_pc;
    m_pc  = np;
    m_mis = mis;
    chk_state();
  endtask

  initial begin
    int unsigned k;
    int unsigned exp_ret[4] = '{32'h054, 32'h044, 32'h034, 32'h024};

    mid_reset();
    repeat (3) step(0, 0, 0, 0, 0, 0, 0);
    chk("free_pc", pc, 'h00C);
    chk("free_pc_last", pc_last, 'h008);
    mid_reset();

    step(0, 0, 0, 1, 'h3FC, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("wrap_pc", pc, 'h000);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("stall_pc", pc, 'h000);
    chk("stall_pc_last", pc_last, 'h3FC);

    step(1, 1, 'h123, 1, 'h200, 0, 0);
    chk("br_pc", pc, 'h120);
    chk("br_misalign", misalign, 1);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("misalign_pulse", misalign, 0);

`ifdef PCGEN_RAS_EN
    step(0, 0, 0, 1, 'h010, 0, 0);
    step(0, 0, 0, 1, 'h100, 1, 0);
    chk("call_pc", pc, 'h100);
    chk("call_ras_empty", ras_empty, 0);
    step(0, 0, 0, 0, 'h2A0, 0, 1);
    chk("ret_pc", pc, 'h014);
    step(0, 0, 0, 0, 'h2A4, 0, 1);
    chk("ret_empty_pc", pc, 'h2A4);
    chk("ret_empty_err", ras_err, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("err_sticky", ras_err, 1);
    mid_reset();

    for (int unsigned a = 1; a <= 5; a++) begin
      step(0, 0, 0, 1, a * 'h10, 0, 0);
      step(0, 0, 0, 1, 'h300, 1, 0);
    end
    chk("five_calls_full", ras_full, 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 'h3F0, 0, 1);
      chk("ret_seq_pc", pc, exp_ret[i]);
    end
    chk("drained_empty", ras_empty, 1);
    step(0, 1, 'h040, 1, 'h300, 1, 0);
    chk("br_blocks_push", ras_empty, 1);
`else
    step(0, 0, 0, 0, 'h080, 0, 1);
    chk("ret_nores_pc", pc, 'h080);
    chk("ret_nores_err", ras_err, 0);
`endif

    repeat (400) begin
      k = $urandom_range(0, 15);
      step($urandom_range(0, 3) == 0, k == 0, $urandom_range(0, MOD - 1),
           k inside {1, 2, 3}, $urandom_range(0, MOD - 1), $urandom_range(0, 1) == 1,
           k inside {0, 4, 5});
      if ($urandom_range(0, 99) == 0) mid_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
